// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//   Bit-serial N-bit adder. An accepted start captures a and b. The adder then
//   processes one bit per clock, LSB first, through two cascaded half adders
//   and a carry flip-flop. After N bit-steps it publishes sum/cout and pulses
//   done for one cycle.
//
// Parameters
//   N      operand/result width in bits (N >= 1)
//
// Ports
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   start  in   request to add, accepted only while idle
//   a, b   in   N-bit operands, captured on an accepted start
//   sum    out  registered result a+b mod 2^N, updated only at completion
//   cout   out  registered carry out of bit N-1, updated only at completion
//   busy   out  high while bit-steps are in progress
//   done   out  one-cycle pulse right after sum/cout were updated
// -----------------------------------------------------------------------------
module serial_adder #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         busy,
  output logic         done
);

  // Counter must represent 0..N, hence clog2(N+1) bits (1 bit when N == 1).
  localparam int            CW       = $clog2(N + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  // Half-adder primitives shared by both adder stages.
  function automatic logic ha_sum(input logic x, input logic y);
    return x ^ y;
  endfunction

  function automatic logic ha_carry(input logic x, input logic y);
    return x & y;
  endfunction

  state_e         state_q, state_d;
  logic [N-1:0]   ra_q, ra_d;
  logic [N-1:0]   rb_q, rb_d;
  logic           c_q, c_d;
  logic [N-1:0]   acc_q, acc_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   sum_q, sum_d;
  logic           cout_q, cout_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  logic           p_s, g_s, s_s, t_s, carry_s;
  logic [N-1:0]   acc_shift_s;

  // Bit-step datapath: two half adders on the current LSBs and stored carry.
  always_comb begin
    p_s     = ha_sum(ra_q[0], rb_q[0]);
    g_s     = ha_carry(ra_q[0], rb_q[0]);
    s_s     = ha_sum(p_s, c_q);
    t_s     = ha_carry(p_s, c_q);
    carry_s = g_s | t_s;
    // The new sum bit enters at the MSB so that after N steps bit 0 of the
    // result sits at acc[0]. Written as shift-then-set so N == 1 needs no slice.
    acc_shift_s        = acc_q >> 1;
    acc_shift_s[N-1]   = s_s;
  end

  // Next-state and next-output logic for the IDLE/SHIFT/DONE sequencer.
  always_comb begin
    state_d = state_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    c_d     = c_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          ra_d    = a;
          rb_d    = b;
          c_d     = 1'b0;
          acc_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = S_SHIFT;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_SHIFT: begin
        c_d   = carry_s;
        acc_d = acc_shift_s;
        ra_d  = ra_q >> 1;
        rb_d  = rb_q >> 1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          // Last bit: publish the completed word directly from this step.
          sum_d   = acc_shift_s;
          cout_d  = carry_s;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          busy_d  = 1'b1;
          state_d = S_SHIFT;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, datapath and output registers; reset discards any addition in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ra_q    <= '0;
      rb_q    <= '0;
      c_q     <= 1'b0;
      acc_q   <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      c_q     <= c_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_adder
//   Self-checking bench for serial_adder with an N=8 and an N=1 instance.
//   Expected results come from plain integer addition of the operands.
// -----------------------------------------------------------------------------
module tb_serial_adder;

  logic       clk;
  logic       rst_n;

  logic       start8;
  logic [7:0] a8, b8, sum8;
  logic       cout8, busy8, done8;

  logic       start1;
  logic [0:0] a1, b1, sum1;
  logic       cout1, busy1, done1;

  int checks;
  int failures;

  serial_adder #(.N(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start8),
    .a     (a8),
    .b     (b8),
    .sum   (sum8),
    .cout  (cout8),
    .busy  (busy8),
    .done  (done8)
  );

  serial_adder #(.N(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start1),
    .a     (a1),
    .b     (b1),
    .sum   (sum1),
    .cout  (cout1),
    .busy  (busy1),
    .done  (done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus driver for one N=8 addition. Returns when done is seen (at a
  // negedge) or the cycle budget runs out. Also counts busy and result-hold
  // violations observed during the SHIFT cycles.
  task automatic add8(input logic [7:0] av, input logic [7:0] bv, input bit hold,
                      output int lat, output int busy_err, output int hold_err,
                      output logic [7:0] s_o, output logic c_o);
    logic [7:0] s_prev;
    logic       c_prev;
    s_prev = sum8;
    c_prev = cout8;
    @(negedge clk);
    start8 = 1'b1;
    a8     = av;
    b8     = bv;
    @(posedge clk);
    @(negedge clk);
    if (hold) begin
      a8 = 8'h11;
      b8 = 8'h22;
    end else begin
      start8 = 1'b0;
    end
    lat      = 0;
    busy_err = 0;
    hold_err = 0;
    while (done8 !== 1'b1 && lat < 14) begin
      if (busy8 !== 1'b1) busy_err++;
      if (sum8 !== s_prev || cout8 !== c_prev) hold_err++;
      @(negedge clk);
      lat++;
    end
    if (busy8 !== 1'b0) busy_err++;
    s_o = sum8;
    c_o = cout8;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (sum8 !== 8'h00 || cout8 !== 1'b0 || busy8 !== 1'b0 || done8 !== 1'b0) begin
      failures++;
      $display("FAIL reset8: got sum=%h cout=%b busy=%b done=%b, want 00 0 0 0", sum8, cout8, busy8, done8);
    end
    checks++;
    if (sum1 !== 1'b0 || cout1 !== 1'b0 || busy1 !== 1'b0 || done1 !== 1'b0) begin
      failures++;
      $display("FAIL reset1: got sum=%b cout=%b busy=%b done=%b, want 0 0 0 0", sum1, cout1, busy1, done1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy8 !== 1'b0 || done8 !== 1'b0 || sum8 !== 8'h00) begin
      failures++;
      $display("FAIL idle_after_reset: got busy=%b done=%b sum=%h, want 0 0 00", busy8, done8, sum8);
    end
  endtask

  task automatic run_and_check(input string name, input logic [7:0] av, input logic [7:0] bv);
    int lat, be, he;
    logic [7:0] s;
    logic c;
    logic [8:0] exp;
    exp = {1'b0, av} + {1'b0, bv};
    add8(av, bv, 1'b0, lat, be, he, s, c);
    checks++;
    if (lat != 8) begin
      failures++;
      $display("FAIL %s_latency: got %0d, want 8", name, lat);
    end
    checks++;
    if ({c, s} !== exp) begin
      failures++;
      $display("FAIL %s_result: %h+%h got cout=%b sum=%h, want cout=%b sum=%h", name, av, bv, c, s, exp[8], exp[7:0]);
    end
    checks++;
    if (be != 0 || he != 0) begin
      failures++;
      $display("FAIL %s_busy_hold: got busy_err=%0d hold_err=%0d, want 0 0", name, be, he);
    end
  endtask

  task automatic test_basic();
    run_and_check("basic", 8'h3C, 8'h5A);
    @(negedge clk);
    checks++;
    if (done8 !== 1'b0 || busy8 !== 1'b0) begin
      failures++;
      $display("FAIL basic_done_pulse: got done=%b busy=%b, want 0 0", done8, busy8);
    end
  endtask

  task automatic test_carry_ripple();
    run_and_check("ripple_ff_01", 8'hFF, 8'h01);
    run_and_check("ripple_ff_ff", 8'hFF, 8'hFF);
    run_and_check("ripple_00_00", 8'h00, 8'h00);
  endtask

  task automatic test_start_ignored();
    int lat, be, he, j;
    logic [7:0] s;
    logic c;
    add8(8'h3C, 8'h5A, 1'b1, lat, be, he, s, c);
    checks++;
    if (lat != 8 || s !== 8'h96 || c !== 1'b0 || be != 0) begin
      failures++;
      $display("FAIL ignore_start: got lat=%0d sum=%h cout=%b busy_err=%0d, want 8 96 0 0", lat, s, c, be);
    end
    // start still high: edge after done lands in DONE (ignored), next one is accepted.
    @(negedge clk);
    checks++;
    if (done8 !== 1'b0 || busy8 !== 1'b0) begin
      failures++;
      $display("FAIL ignore_single_done: got done=%b busy=%b, want 0 0", done8, busy8);
    end
    @(negedge clk);
    checks++;
    if (busy8 !== 1'b1) begin
      failures++;
      $display("FAIL next_start_n_plus_2: got busy=%b, want 1", busy8);
    end
    start8 = 1'b0;
    j = 0;
    while (done8 !== 1'b1 && j < 14) begin
      @(negedge clk);
      j++;
    end
    checks++;
    if (j != 8 || sum8 !== 8'h33 || cout8 !== 1'b0) begin
      failures++;
      $display("FAIL second_add: got lat=%0d sum=%h cout=%b, want 8 33 0", j, sum8, cout8);
    end
  endtask

  task automatic test_reset_mid_shift();
    int pulses, busies;
    @(negedge clk);
    start8 = 1'b1;
    a8     = 8'hAA;
    b8     = 8'h55;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (sum8 !== 8'h00 || cout8 !== 1'b0 || busy8 !== 1'b0 || done8 !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset: got sum=%h cout=%b busy=%b done=%b, want 00 0 0 0", sum8, cout8, busy8, done8);
    end
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    busies = 0;
    repeat (12) begin
      @(negedge clk);
      if (done8 === 1'b1) pulses++;
      if (busy8 === 1'b1) busies++;
    end
    checks++;
    if (pulses != 0 || busies != 0) begin
      failures++;
      $display("FAIL no_done_after_reset: got done_pulses=%0d busy_cycles=%0d, want 0 0", pulses, busies);
    end
    run_and_check("after_reset", 8'hAA, 8'h55);
  endtask

  task automatic test_result_hold();
    run_and_check("hold_80_80", 8'h80, 8'h80);
    run_and_check("hold_01_01", 8'h01, 8'h01);
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      logic [7:0] av, bv;
      av = 8'($urandom);
      bv = 8'($urandom);
      run_and_check("random", av, bv);
    end
  endtask

  task automatic test_n1();
    for (int i = 0; i < 4; i++) begin
      logic [1:0] ab;
      logic [1:0] exp;
      int j;
      ab  = 2'(i);
      exp = {1'b0, ab[1]} + {1'b0, ab[0]};
      @(negedge clk);
      start1 = 1'b1;
      a1     = ab[1];
      b1     = ab[0];
      @(posedge clk);
      @(negedge clk);
      start1 = 1'b0;
      checks++;
      if (busy1 !== 1'b1) begin
        failures++;
        $display("FAIL n1_busy: a=%b b=%b got busy=%b, want 1", ab[1], ab[0], busy1);
      end
      j = 0;
      while (done1 !== 1'b1 && j < 6) begin
        @(negedge clk);
        j++;
      end
      checks++;
      if (j != 1 || {cout1, sum1} !== exp) begin
        failures++;
        $display("FAIL n1_add: a=%b b=%b got lat=%0d cout=%b sum=%b, want 1 %b %b", ab[1], ab[0], j, cout1, sum1, exp[1], exp[0]);
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    start8   = 1'b0;
    a8       = 8'h00;
    b8       = 8'h00;
    start1   = 1'b0;
    a1       = 1'b0;
    b1       = 1'b0;
    test_reset();
    test_basic();
    test_carry_ripple();
    test_start_ignored();
    test_reset_mid_shift();
    test_result_hold();
    test_random();
    test_n1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
